// File: rtl/uart_cmd_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_assembler
//  Function : Collects NUM_BYTES received UART bytes (MSB first) into one
//             command word, with inter-byte timeout and overwrite flagging.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_assembler #(
    parameter int NUM_BYTES   = 3,
    parameter int TIMEOUT_CYC = 26000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_rdy,
    input  logic [7:0]             rx_data,
    output logic                   clr_rx_rdy,
    output logic [8*NUM_BYTES-1:0] cmd,
    output logic                   cmd_rdy,
    input  logic                   clr_cmd_rdy,
    output logic                   frame_err,
    output logic                   cmd_ovr
);

    localparam int c_CMD_W = 8 * NUM_BYTES;
    localparam int c_CNT_W = $clog2(NUM_BYTES + 1);
    localparam int c_GAP_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [c_CNT_W-1:0] c_LAST_IDX   = c_CNT_W'(NUM_BYTES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_GAP_W-1:0] c_GAP_EXPIRE = c_GAP_W'(TIMEOUT_CYC - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_MAX    = c_GAP_W'(TIMEOUT_CYC);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE    = c_GAP_W'(1);

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_byte_cnt;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic [c_CMD_W-1:0]   r_shift;
    logic [c_CMD_W-1:0]   r_cmd;
    logic                 r_cmd_rdy;
    logic                 r_clr_rx_rdy;
    logic                 r_frame_err;
    logic                 r_cmd_ovr;
    logic                 r_rx_taken;

    logic                 w_capture;
    logic                 w_complete;
    logic                 w_gap_run;
    logic                 w_timeout;
    logic [c_CMD_W-1:0]   w_shift_nxt;

    // A byte is only taken once rx_rdy has been seen low since the last
    // capture, so a receiver that drops its flag late is not read twice.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (rx_rdy && !r_rx_taken) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK:  w_state_nxt = ST_WAIT;
            default: w_state_nxt = ST_WAIT;
        endcase
        w_complete  = w_capture && (r_byte_cnt == c_LAST_IDX);
        w_gap_run   = (r_state == ST_WAIT) && (r_byte_cnt != '0) && !rx_rdy;
        w_timeout   = w_gap_run && (r_gap_cnt == c_GAP_EXPIRE);
        w_shift_nxt = {r_shift[c_CMD_W-9:0], rx_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_shift      <= '0;
            r_cmd        <= '0;
            r_cmd_rdy    <= 1'b0;
            r_clr_rx_rdy <= 1'b0;
            r_frame_err  <= 1'b0;
            r_cmd_ovr    <= 1'b0;
            r_rx_taken   <= 1'b0;
        end else begin
            r_clr_rx_rdy <= w_capture;
            r_frame_err  <= w_timeout;
            r_cmd_ovr    <= w_complete && r_cmd_rdy && !clr_cmd_rdy;

            if (w_capture) begin
                r_rx_taken <= 1'b1;
            end else if (!rx_rdy) begin
                r_rx_taken <= 1'b0;
            end

            // Capture takes priority over expiry: a byte on the expiry cycle continues the frame.
            if (w_capture) begin
                r_shift    <= w_shift_nxt;
                r_gap_cnt  <= '0;
                r_byte_cnt <= w_complete ? '0 : (r_byte_cnt + c_CNT_ONE);
            end else if (w_timeout) begin
                r_byte_cnt <= '0;
                r_gap_cnt  <= '0;
            end else if (r_byte_cnt == '0) begin
                r_gap_cnt  <= '0;
            end else if (w_gap_run && (r_gap_cnt != c_GAP_MAX)) begin
                r_gap_cnt  <= r_gap_cnt + c_GAP_ONE;
            end

            if (w_complete) begin
                r_cmd     <= w_shift_nxt;
                r_cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    assign clr_rx_rdy = r_clr_rx_rdy;
    assign cmd        = r_cmd;
    assign cmd_rdy    = r_cmd_rdy;
    assign frame_err  = r_frame_err;
    assign cmd_ovr    = r_cmd_ovr;

endmodule
`default_nettype wire
